// File: rtl/mem_ctrl_pkg.sv
// Shared types and default constants for the data-memory access controller.
// Contents:
//   state_e        - controller state encoding
//   DEF_INT_BASE   - first byte address of the internal data-memory window
//   DEF_INT_LIMIT  - last byte address of the internal window (inclusive)
//   DEF_TIMEOUT    - external-bus cycles allowed without an acknowledge
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INT,
    INT_RD,
    EXT,
    DONE
  } state_e;

  localparam logic [31:0] DEF_INT_BASE  = 32'h0000_0500;
  localparam logic [31:0] DEF_INT_LIMIT = 32'h0000_08FF;
  localparam int          DEF_TIMEOUT   = 16;

endpackage

// File: rtl/addr_range_decode.sv
// Combinational address classifier for the access controller.
// Ports:
//   address_i    - byte address of the CPU request
//   hit_o        - address lies inside [INT_BASE, INT_LIMIT]
//   misaligned_o - address is not word aligned
module addr_range_decode
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_BASE  = DEF_INT_BASE,
  parameter logic [31:0] INT_LIMIT = DEF_INT_LIMIT
) (
  input  logic [31:0] address_i,
  output logic        hit_o,
  output logic        misaligned_o
);

  // Both bounds are inclusive so the last word of the window still hits.
  assign hit_o        = (address_i >= INT_BASE) && (address_i <= INT_LIMIT);
  assign misaligned_o = (address_i[1:0] != 2'b00);

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between the CPU load/store port and two
// targets: the internal data memory (active-low chip select) and an external
// req/ack bus. One request is latched, routed, sequenced, and completed with
// a one-cycle Done pulse; the CPU is stalled until then.
// Ports:
//   clk_i, reset_i            - clock, synchronous active-high reset
//   req_i, we_i, address_i,
//   wrData_i                  - CPU request (held until done_o)
//   stall_o, done_o,
//   busErr_o, rdData_o        - CPU response
//   intCs_o, intWe_o,
//   intAddr_o, intWrData_o,
//   intRdData_i               - internal memory port
//   extReq_o, extWe_o,
//   extAddr_o, extWrData_o,
//   extAck_i, extRdData_i     - external bus port
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_BASE  = DEF_INT_BASE,
  parameter logic [31:0] INT_LIMIT = DEF_INT_LIMIT,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] address_i,
  input  logic [31:0] wrData_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        busErr_o,
  output logic [31:0] rdData_o,
  output logic        intCs_o,
  output logic        intWe_o,
  output logic [9:0]  intAddr_o,
  output logic [31:0] intWrData_o,
  input  logic [31:0] intRdData_i,
  output logic        extReq_o,
  output logic        extWe_o,
  output logic [31:0] extAddr_o,
  output logic [31:0] extWrData_o,
  input  logic        extAck_i,
  input  logic [31:0] extRdData_i
);

  localparam int CntW = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wrData_q, wrData_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdData_q, rdData_d;
  logic              hit, misaligned;

  // The decode looks at the live CPU address because it is only consulted in
  // IDLE, on the same edge that latches the request.
  addr_range_decode #(
    .INT_BASE  (INT_BASE),
    .INT_LIMIT (INT_LIMIT)
  ) u_decode (
    .address_i    (address_i),
    .hit_o        (hit),
    .misaligned_o (misaligned)
  );

  // All controller state lives here; reset releases any pending bus activity
  // because the strobes are decoded from the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wrData_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdData_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wrData_q <= wrData_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdData_q <= rdData_d;
    end
  end

  // Next-state and strobe logic. The external counter holds the number of
  // EXT cycles already spent, so reaching TIMEOUT-1 without an ack means the
  // TIMEOUT-th request cycle has just passed. Ack is tested first so an ack
  // on that final cycle still completes cleanly.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wrData_d = wrData_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rdData_d = rdData_q;
    intCs_o  = 1'b1;
    intWe_o  = 1'b0;
    extReq_o = 1'b0;
    extWe_o  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (req_i) begin
          addr_d   = address_i;
          we_d     = we_i;
          wrData_d = wrData_i;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (hit) begin
            state_d = INT;
          end else begin
            state_d = EXT;
          end
        end
      end
      INT: begin
        intCs_o = 1'b0;
        intWe_o = we_q;
        state_d = we_q ? DONE : INT_RD;
      end
      INT_RD: begin
        rdData_d = intRdData_i;
        state_d  = DONE;
      end
      EXT: begin
        extReq_o = 1'b1;
        extWe_o  = we_q;
        if (extAck_i) begin
          if (!we_q) begin
            rdData_d = extRdData_i;
          end
          state_d = DONE;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only the low ten bits of the offset are needed, and they are unaffected
  // by the upper address bits, so the subtraction is done at that width.
  assign intAddr_o   = addr_q[9:0] - INT_BASE[9:0];
  assign intWrData_o = wrData_q;
  assign extAddr_o   = addr_q;
  assign extWrData_o = wrData_q;

  assign done_o   = (state_q == DONE);
  assign busErr_o = done_o & err_q;
  assign rdData_o = rdData_q;
  assign stall_o  = req_i & ~done_o;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Each access pushes its expected
// completion into a scoreboard queue; a monitor pops and compares on Done.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] address_i;
  logic [31:0] wrData_i;
  logic        stall_o;
  logic        done_o;
  logic        busErr_o;
  logic [31:0] rdData_o;
  logic        intCs_o;
  logic        intWe_o;
  logic [9:0]  intAddr_o;
  logic [31:0] intWrData_o;
  logic [31:0] intRdData_i;
  logic        extReq_o;
  logic        extWe_o;
  logic [31:0] extAddr_o;
  logic [31:0] extWrData_o;
  logic        extAck_i;
  logic [31:0] extRdData_i;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          doneCyc;
  } exp_t;

  exp_t        sbQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          cyc         = 0;
  logic [31:0] memModel [0:255];

  mem_access_ctrl dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .address_i   (address_i),
    .wrData_i    (wrData_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .busErr_o    (busErr_o),
    .rdData_o    (rdData_o),
    .intCs_o     (intCs_o),
    .intWe_o     (intWe_o),
    .intAddr_o   (intAddr_o),
    .intWrData_o (intWrData_o),
    .intRdData_i (intRdData_i),
    .extReq_o    (extReq_o),
    .extWe_o     (extWe_o),
    .extAddr_o   (extAddr_o),
    .extWrData_o (extWrData_o),
    .extAck_i    (extAck_i),
    .extRdData_i (extRdData_i)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Behavioural internal memory: one-cycle read latency after chip select.
  always @(posedge clk_i) begin
    if (!intCs_o) begin
      if (intWe_o) memModel[intAddr_o[9:2]] <= intWrData_o;
      intRdData_i <= memModel[intAddr_o[9:2]];
    end
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("spuriousDone", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("busErr", {31'd0, busErr_o}, {31'd0, e.err});
        checkOutput("rdData", rdData_o, e.rd);
        checkOutput("doneCycle", cyc, e.doneCyc);
      end
    end
  end

  // Drives one access from cycle 0, optionally acks the external bus in
  // cycle ackCyc, records strobe activity, and waits (bounded) for Done.
  task automatic applyStimulus(
    input logic [31:0] addr, input logic we, input logic [31:0] wdata,
    input int ackCyc, input logic [31:0] ackData,
    input logic expErr, input logic [31:0] expRd, input int expDone,
    input int expIntLow, input int expExtFirst, input int expExtLast
  );
    int          intLow = 0;
    int          extFirst = 0;
    int          extLast = 0;
    logic [31:0] intAddrSeen = '0;
    logic [31:0] extAddrSeen = '0;
    bit          seenDone = 0;
    exp_t        e;
    e.err = expErr;
    e.rd = expRd;
    e.doneCyc = expDone;
    sbQ.push_back(e);
    reset_i   = 1'b0;
    req_i     = 1'b1;
    we_i      = we;
    address_i = addr;
    wrData_i  = wdata;
    cyc = 0;
    for (int i = 0; i < 40 && !seenDone; i++) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      if (intCs_o === 1'b0) begin
        intLow++;
        intAddrSeen = {22'd0, intAddr_o};
      end
      if (extReq_o === 1'b1) begin
        if (extFirst == 0) extFirst = cyc;
        extLast = cyc;
        extAddrSeen = extAddr_o;
      end
      if (done_o === 1'b1) begin
        seenDone = 1;
        checkOutput("stallInDone", {31'd0, stall_o}, 32'd0);
        extAck_i = 1'b0;
      end else begin
        checkOutput("stallBusy", {31'd0, stall_o}, 32'd1);
        extAck_i    = (cyc == ackCyc);
        extRdData_i = (cyc == ackCyc) ? ackData : 32'hxxxx_xxxx;
      end
    end
    if (!seenDone) checkOutput("doneWait", 32'd0, 32'd1);
    req_i = 1'b0;
    checkOutput("intCsCycles", intLow, expIntLow);
    checkOutput("extReqFirst", extFirst, expExtFirst);
    checkOutput("extReqLast", extLast, expExtLast);
    if (expIntLow > 0) checkOutput("intAddr", intAddrSeen, (addr - 32'h500) & 32'h3FF);
    if (expExtFirst > 0) checkOutput("extAddr", extAddrSeen, addr);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memModel[i] = 32'd0;
    intRdData_i = '0;
    extAck_i    = 1'b0;
    extRdData_i = '0;
    reset_i     = 1'b1;
    req_i       = 1'b1;
    we_i        = 1'b0;
    address_i   = 32'h500;
    wrData_i    = '0;

    // Reset held with a live request: nothing may move.
    @(posedge clk_i);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("rstIntCs", {31'd0, intCs_o}, 32'd1);
      checkOutput("rstExtReq", {31'd0, extReq_o}, 32'd0);
      checkOutput("rstDone", {31'd0, done_o}, 32'd0);
      checkOutput("rstRdData", rdData_o, 32'd0);
      if (i < 3) @(posedge clk_i);
    end

    // Internal stores and loads, including both window edges.
    applyStimulus(32'h500, 1'b1, 32'hA5A5_0001, 0, '0, 1'b0, 32'h0, 2, 1, 0, 0);
    applyStimulus(32'h8FC, 1'b1, 32'hDEAD_BEEF, 0, '0, 1'b0, 32'h0, 2, 1, 0, 0);
    applyStimulus(32'h8FC, 1'b0, 32'h0, 0, '0, 1'b0, 32'hDEAD_BEEF, 3, 1, 0, 0);
    applyStimulus(32'h500, 1'b0, 32'h0, 0, '0, 1'b0, 32'hA5A5_0001, 3, 1, 0, 0);

    // Just outside the window goes external.
    applyStimulus(32'h4FC, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 0, 1, 2);
    applyStimulus(32'h900, 1'b0, 32'h0, 1, 32'h1111_2222, 1'b0, 32'h1111_2222, 2, 0, 1, 1);
    applyStimulus(32'h1000, 1'b0, 32'h0, 4, 32'h1234_5678, 1'b0, 32'h1234_5678, 5, 0, 1, 4);

    // External store leaves RdData alone.
    applyStimulus(32'h2000, 1'b1, 32'h0000_CAFE, 3, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 4, 0, 1, 3);

    // Timeout without ack, then ack on the last allowed cycle.
    applyStimulus(32'h3000, 1'b0, 32'h0, 0, '0, 1'b1, 32'h1234_5678, 17, 0, 1, 16);
    applyStimulus(32'h3004, 1'b0, 32'h0, 16, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 17, 0, 1, 16);

    // Misaligned access errors out without touching either target.
    applyStimulus(32'h502, 1'b0, 32'h0, 0, '0, 1'b1, 32'h55AA_55AA, 1, 0, 0, 0);

    // Reset in the middle of an external access.
    reset_i   = 1'b0;
    req_i     = 1'b1;
    we_i      = 1'b0;
    address_i = 32'h3000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    checkOutput("midExtReq", {31'd0, extReq_o}, 32'd1);
    reset_i = 1'b1;
    req_i   = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rstExtReqDrop", {31'd0, extReq_o}, 32'd0);
    checkOutput("rstNoDone", {31'd0, done_o}, 32'd0);
    checkOutput("rstRdClear", rdData_o, 32'd0);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("postRstIdle", {31'd0, done_o | extReq_o}, 32'd0);
    end

    // Controller is usable again after reset.
    applyStimulus(32'h8FC, 1'b0, 32'h0, 0, '0, 1'b0, 32'hDEAD_BEEF, 3, 1, 0, 0);

    checkOutput("sbEmpty", sbQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
